// File: rtl/multi_db_pkg.sv
// Shared constants and helpers for the multi-channel debounce/count block.
// No logic, so no latency and no backpressure.
package multi_db_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // A single channel still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_db_counter_db_channel.sv
// One channel: 2-flop sync, stability-counter debounce, edge tick, bounce and event counters.
// Level moves DB_CYCLES+2 cycles after sw settles, tick is registered with it; no backpressure.
module db_channel
  import multi_db_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int SAT       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw,
  input  logic             clr,
  output logic             level,
  output logic             tick,
  output logic [CNT_W-1:0] raw_cnt,
  output logic [CNT_W-1:0] db_cnt
);

  localparam int             K_W   = $clog2(DB_CYCLES);
  localparam logic [K_W-1:0] K_MAX = K_W'(DB_CYCLES - 1);

  logic           s_meta;
  logic           s;
  logic           s_prev;
  logic [K_W-1:0] k;
  logic           flip;
  logic           edge_hit;
  logic           raw_rise;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if ((SAT != 0) && (&v)) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  assign flip     = (s != level) && (k == K_MAX);
  assign raw_rise = s & ~s_prev;

  always_comb begin
    edge_hit = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: edge_hit = flip & s;
      EDGE_FALL: edge_hit = flip & ~s;
      default:   edge_hit = flip;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_prev <= 1'b0;
      level  <= 1'b0;
      tick   <= 1'b0;
      k      <= '0;
    end else begin
      s_meta <= sw;
      s      <= s_meta;
      s_prev <= s;
      tick   <= edge_hit;
      // Any sample matching the current level restarts the stability window.
      if (s == level) begin
        k <= '0;
      end else if (k == K_MAX) begin
        level <= s;
        k     <= '0;
      end else begin
        k <= k + K_W'(1);
      end
    end
  end

  // Clear wins over a coincident increment; that edge is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raw_cnt <= '0;
      db_cnt  <= '0;
    end else begin
      if (clr) begin
        raw_cnt <= '0;
      end else if (raw_rise) begin
        raw_cnt <= bump(raw_cnt);
      end
      if (clr) begin
        db_cnt <= '0;
      end else if (tick) begin
        db_cnt <= bump(db_cnt);
      end
    end
  end

endmodule

// File: rtl/multi_db_counter.sv
// N_CH debounce/count channels plus a registered counter read-out selected by sel.
// Read-out lags sel or counter changes by 1 cycle; no backpressure.
module multi_db_counter
  import multi_db_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 8,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int SAT       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CH-1:0]            sw,
  input  logic [N_CH-1:0]            clr,
  input  logic [sel_width(N_CH)-1:0] sel,
  output logic [N_CH-1:0]            db_level,
  output logic [N_CH-1:0]            db_tick,
  output logic [CNT_W-1:0]           rd_raw,
  output logic [CNT_W-1:0]           rd_db
);

  logic [CNT_W-1:0] raw_cnt [N_CH];
  logic [CNT_W-1:0] db_cnt  [N_CH];
  logic [CNT_W-1:0] raw_mux;
  logic [CNT_W-1:0] db_mux;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    db_channel #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE),
      .SAT       (SAT)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .sw      (sw[g]),
      .clr     (clr[g]),
      .level   (db_level[g]),
      .tick    (db_tick[g]),
      .raw_cnt (raw_cnt[g]),
      .db_cnt  (db_cnt[g])
    );
  end

  // Select codes past the last channel fall through to zero.
  always_comb begin
    raw_mux = '0;
    db_mux  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(sel) == i) begin
        raw_mux = raw_cnt[i];
        db_mux  = db_cnt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_raw <= '0;
      rd_db  <= '0;
    end else begin
      rd_raw <= raw_mux;
      rd_db  <= db_mux;
    end
  end

endmodule
